// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: multi-cycle MULT/MULTU/DIV/DIVU with a fixed busy window,
// plus single-cycle MTHI/MTLO writes. Results commit to hi/lo only on the final busy edge.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [31:0] w_hi_nxt, w_lo_nxt;
  logic        w_accept, w_load, w_signed;
  logic        w_sgn_a, w_sgn_b;
  logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_quot, w_rem;
  logic [63:0] w_prod;

  // Datapath works only on the operands captured at the accept edge.
  always_comb begin
    w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    w_sgn_a  = w_signed & r_a[31];
    w_sgn_b  = w_signed & r_b[31];
    w_abs_a  = w_sgn_a ? -r_a : r_a;
    w_abs_b  = w_sgn_b ? -r_b : r_b;
    if (w_signed) w_prod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    else          w_prod = {32'd0, r_a} * {32'd0, r_b};
    w_q      = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
    w_r      = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;
    w_quot   = (w_sgn_a ^ w_sgn_b) ? -w_q : w_q;
    w_rem    = w_sgn_a ? -w_r : w_r;
  end

  // A request is taken in IDLE or on the edge where the running operation finishes.
  assign w_accept = start && ((r_state == S_IDLE) || (r_cnt == 5'd0));
  assign w_load   = w_accept && (op <= OP_DIVU);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    if (r_state != S_IDLE) begin
      if (r_cnt == 5'd0) begin
        w_state_nxt = S_IDLE;
        if (r_state == S_MUL) begin
          w_hi_nxt = w_prod[63:32];
          w_lo_nxt = w_prod[31:0];
        end else if (r_b != 32'd0) begin
          w_hi_nxt = w_rem;
          w_lo_nxt = w_quot;
        end
      end else begin
        w_cnt_nxt = r_cnt - 5'd1;
      end
    end
    // Commit above happens first so an MTHI/MTLO on the same edge overrides one half.
    if (w_accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          w_state_nxt = S_MUL;
          w_cnt_nxt   = MUL_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          w_state_nxt = S_DIV;
          w_cnt_nxt   = DIV_LOAD;
        end
        OP_MTHI: w_hi_nxt = rs_data;
        OP_MTLO: w_lo_nxt = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_load) begin
        r_op <= op;
        r_a  <= rs_data;
        r_b  <= rt_data;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors plus randomized ops against an arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ncyc(input logic [2:0] o);
    if (o < 3'd2) return 5;
    if (o < 3'd4) return 10;
    return 0;
  endfunction

  // Architectural effect of one accepted op on HI/LO.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint p, q, r;
    longint unsigned pu;
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = longint'(ia) * longint'(ib); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin pu = 64'(a) * 64'(b); m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd2: if (b != 0) begin
        q = longint'(ia) / longint'(ib);
        r = longint'(ia) % longint'(ib);
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
  endtask

  // One op from IDLE; optional ignored pulses during busy (random, or MTLO 0xAAAA at pulse_at).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rnd, input int pulse_at);
    int n = ncyc(o);
    @(negedge clk);
    drive(o, a, b);
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    for (int i = 1; i <= n; i++) begin
      check("busy_during", 32'(busy), 32'd1);
      check("hi_hold", hi, m_hi);
      check("lo_hold", lo, m_lo);
      if (i < n && i == pulse_at) drive(3'd5, 32'h0000AAAA, 32'd0);
      else if (i < n && rnd && $urandom_range(0, 2) == 0)
        drive(3'($urandom_range(0, 7)), $urandom, $urandom);
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    model(o, a, b);
    check("busy_done", 32'(busy), 32'd0);
    check("hi_result", hi, m_hi);
    check("lo_result", lo, m_lo);
  endtask

  // Second request issued on the edge where the first completes.
  task automatic b2b(input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [2:0] o2, input logic [31:0] a2, input logic [31:0] b2);
    int n1 = ncyc(o1);
    int n2 = ncyc(o2);
    @(negedge clk);
    drive(o1, a1, b1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= n1; i++) begin
      check("b2b_busy1", 32'(busy), 32'd1);
      if (i == n1) drive(o2, a2, b2);
      @(negedge clk);
    end
    start = 1'b0;
    model(o1, a1, b1);
    if (n2 == 0) model(o2, a2, b2);
    for (int j = 1; j <= n2; j++) begin
      check("b2b_busy2", 32'(busy), 32'd1);
      check("b2b_hi_mid", hi, m_hi);
      check("b2b_lo_mid", lo, m_lo);
      @(negedge clk);
    end
    if (n2 != 0) model(o2, a2, b2);
    check("b2b_busy_end", 32'(busy), 32'd0);
    check("b2b_hi_end", hi, m_hi);
    check("b2b_lo_end", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 0);
    check("mult_hi_const", hi, 32'hFFFFFFFF);
    check("mult_lo_const", lo, 32'hFFFFFFFE);
    run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 0);
    check("multu_hi_const", hi, 32'h00000001);
    check("multu_lo_const", lo, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 0);
    check("div_lo_const", lo, 32'hFFFFFFFD);
    check("div_hi_const", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'd7, 32'd2, 1'b0, 0);
    check("divu_lo_const", lo, 32'd3);
    check("divu_hi_const", hi, 32'd1);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);

    run_op(3'd4, 32'h00001234, 32'd0, 1'b0, 0);
    run_op(3'd5, 32'h00005678, 32'd0, 1'b0, 0);
    run_op(3'd3, 32'd7, 32'd0, 1'b0, 0);
    check("div0_hi_const", hi, 32'h00001234);
    check("div0_lo_const", lo, 32'h00005678);
    run_op(3'd6, 32'hDEADBEEF, 32'd1, 1'b0, 0);
    run_op(3'd7, 32'hDEADBEEF, 32'd1, 1'b0, 0);

    run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, 1'b0, 2);
    check("mtlo_ignored_lo", lo, 32'hFFFFFFEB);

    b2b(3'd0, 32'd3, 32'd4, 3'd3, 32'd12, 32'd5);
    check("b2b_divu_hi", hi, 32'd2);
    check("b2b_divu_lo", lo, 32'd2);
    b2b(3'd1, 32'h12345678, 32'h9ABCDEF0, 3'd4, 32'hCAFEF00D, 32'd0);
    b2b(3'd2, 32'd100, 32'hFFFFFFF9, 3'd5, 32'h0BADF00D, 32'd0);

    // Abort a divide with reset at cycle 4; a start on the reset edge must also be dropped.
    @(negedge clk);
    drive(3'd2, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(3'd4, 32'h5555AAAA, 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
